// File: rtl/reset_seq_pkg.sv
// Shared state encoding, reset-cause codes and default sizing for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_BTN  = 2'd2;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 80000;
  localparam int DEFAULT_STRETCH_CYCLES  = 16;

  // Counter width that holds 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit; clears to 0 on reset.
module sync_bit
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Clean J1 core reset from clock-manager lock and a debounced board button.
// Optional RESET_SEQ_LOSS_COUNT_EN adds a saturating 8-bit lock-loss counter output.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int STRETCH_CYCLES  = DEFAULT_STRETCH_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       isLocked,
  input  logic       extReset,
  output logic       coreReset,
  output logic [1:0] resetCause
`ifdef RESET_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0] lossCount
`endif
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int ST_W = cnt_width(STRETCH_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);

  logic            lockSync;
  logic            btnSync;
  logic            btnStable;
  logic [DB_W-1:0] dbCnt;
  logic [ST_W-1:0] stretchCnt;
  logic            abort;
  seq_state_t      state;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (isLocked),
    .q     (lockSync)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (extReset),
    .q     (btnSync)
  );

  // A new button level is only accepted after it has held for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbCnt     <= '0;
      btnStable <= 1'b0;
    end else if (btnSync == btnStable) begin
      dbCnt <= '0;
    end else if (dbCnt == DB_LAST) begin
      btnStable <= btnSync;
      dbCnt     <= '0;
    end else begin
      dbCnt <= dbCnt + DB_W'(1);
    end
  end

  assign abort = !lockSync || btnStable;

  // coreReset is computed from the next state so it drops only on entry to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      stretchCnt <= '0;
      coreReset  <= 1'b1;
      resetCause <= CAUSE_POR;
`ifdef RESET_SEQ_LOSS_COUNT_EN
      lossCount  <= 8'd0;
`endif
    end else begin
      coreReset <= 1'b1;
      case (state)
        WAIT_LOCK: begin
          if (!abort) begin
            state      <= STRETCH;
            stretchCnt <= '0;
          end
        end
        STRETCH: begin
          if (abort) begin
            state <= WAIT_LOCK;
          end else if (stretchCnt == ST_LAST) begin
            state     <= RUN;
            coreReset <= 1'b0;
          end else begin
            stretchCnt <= stretchCnt + ST_W'(1);
          end
        end
        RUN: begin
          if (abort) begin
            state      <= WAIT_LOCK;
            resetCause <= lockSync ? CAUSE_BTN : CAUSE_LOCK;
`ifdef RESET_SEQ_LOSS_COUNT_EN
            if (!lockSync && lossCount != 8'hFF) begin
              lossCount <= lossCount + 8'd1;
            end
`endif
          end else begin
            coreReset <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with a shortened debounce window.
// Define RESET_SEQ_LOSS_COUNT_EN to also exercise the lock-loss counter.
module tb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int DB   = 256;
  localparam int ST   = 16;
  localparam int LOCK_FALL = SYNC + ST + 1;
  localparam int BTN_RISE  = SYNC + DB + 1;
  localparam int BTN_FALL  = SYNC + DB + ST + 1;

  localparam logic [1:0] C_POR  = 2'd0;
  localparam logic [1:0] C_LOCK = 2'd1;
  localparam logic [1:0] C_BTN  = 2'd2;

  typedef struct packed {
    logic       coreReset;
    logic [1:0] cause;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       isLocked;
  logic       extReset;
  logic       coreReset;
  logic [1:0] resetCause;
`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [7:0] lossCount;
`endif

  int   testsRun    = 0;
  int   testsFailed = 0;
  exp_t expQ[$];

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DB),
    .STRETCH_CYCLES  (ST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .isLocked   (isLocked),
    .extReset   (extReset),
    .coreReset  (coreReset),
    .resetCause (resetCause)
`ifdef RESET_SEQ_LOSS_COUNT_EN
    ,
    .lossCount  (lossCount)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    isLocked = 1'b0;
    extReset = 1'b0;
    #2;
    for (int i = 0; i < 8; i++) begin
      expQ.push_back('{1'b1, C_POR});
      if (i == 2) reset = 1'b0;
      if (i > 0) tick();
      e = expQ.pop_front();
      testsRun++;
      if (coreReset !== e.coreReset || resetCause !== e.cause) begin
        testsFailed++;
        $display("[TB] FAIL reset step %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                 i, coreReset, resetCause, e.coreReset, e.cause);
      end
    end
  endtask

  task automatic test_power_on();
    exp_t e;
    isLocked = 1'b1;
    for (int k = 1; k <= LOCK_FALL + 1; k++) begin
      expQ.push_back('{(k < LOCK_FALL), C_POR});
      tick();
      e = expQ.pop_front();
      testsRun++;
      if (coreReset !== e.coreReset || resetCause !== e.cause) begin
        testsFailed++;
        $display("[TB] FAIL power_on edge %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                 k, coreReset, resetCause, e.coreReset, e.cause);
      end
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    isLocked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      expQ.push_back('{(k >= SYNC + 1), (k >= SYNC + 1) ? C_LOCK : C_POR});
      tick();
      e = expQ.pop_front();
      testsRun++;
      if (coreReset !== e.coreReset || resetCause !== e.cause) begin
        testsFailed++;
        $display("[TB] FAIL lock_loss edge %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                 k, coreReset, resetCause, e.coreReset, e.cause);
      end
    end
    isLocked = 1'b1;
    for (int k = 1; k <= LOCK_FALL + 1; k++) begin
      expQ.push_back('{(k < LOCK_FALL), C_LOCK});
      tick();
      e = expQ.pop_front();
      testsRun++;
      if (coreReset !== e.coreReset || resetCause !== e.cause) begin
        testsFailed++;
        $display("[TB] FAIL relock edge %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                 k, coreReset, resetCause, e.coreReset, e.cause);
      end
    end
  endtask

  task automatic test_button_debounce();
    exp_t e;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 100; k++) begin
        extReset = (k < 50);
        expQ.push_back('{1'b0, C_LOCK});
        tick();
        e = expQ.pop_front();
        testsRun++;
        if (coreReset !== e.coreReset || resetCause !== e.cause) begin
          testsFailed++;
          $display("[TB] FAIL bounce %0d cycle %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                   b, k, coreReset, resetCause, e.coreReset, e.cause);
        end
      end
    end
    extReset = 1'b1;
    for (int k = 1; k <= BTN_RISE + 1; k++) begin
      expQ.push_back('{(k >= BTN_RISE), (k >= BTN_RISE) ? C_BTN : C_LOCK});
      tick();
      e = expQ.pop_front();
      testsRun++;
      if (coreReset !== e.coreReset || resetCause !== e.cause) begin
        testsFailed++;
        $display("[TB] FAIL button_press edge %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                 k, coreReset, resetCause, e.coreReset, e.cause);
      end
    end
    extReset = 1'b0;
    for (int k = 1; k <= BTN_FALL + 1; k++) begin
      expQ.push_back('{(k < BTN_FALL), C_BTN});
      tick();
      e = expQ.pop_front();
      testsRun++;
      if (coreReset !== e.coreReset || resetCause !== e.cause) begin
        testsFailed++;
        $display("[TB] FAIL button_release edge %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                 k, coreReset, resetCause, e.coreReset, e.cause);
      end
    end
  endtask

  task automatic test_stretch_abort();
    exp_t e;
    extReset = 1'b1;
    repeat (BTN_RISE + 1) tick();
    isLocked = 1'b0;
    repeat (5) tick();
    extReset = 1'b0;
    repeat (DB + 10) tick();
    expQ.push_back('{1'b1, C_BTN});
    e = expQ.pop_front();
    testsRun++;
    if (coreReset !== e.coreReset || resetCause !== e.cause) begin
      testsFailed++;
      $display("[TB] FAIL abort_setup: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
               coreReset, resetCause, e.coreReset, e.cause);
    end
    isLocked = 1'b1;
    for (int k = 1; k <= LOCK_FALL + 14; k++) begin
      expQ.push_back('{(k < LOCK_FALL + 13), C_BTN});
      tick();
      if (k == 11) isLocked = 1'b0;
      if (k == 13) isLocked = 1'b1;
      e = expQ.pop_front();
      testsRun++;
      if (coreReset !== e.coreReset || resetCause !== e.cause) begin
        testsFailed++;
        $display("[TB] FAIL stretch_abort edge %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                 k, coreReset, resetCause, e.coreReset, e.cause);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    extReset = 1'b1;
    for (int k = 1; k <= BTN_RISE + 1; k++) begin
      expQ.push_back('{(k >= BTN_RISE), (k >= BTN_RISE) ? C_LOCK : C_BTN});
      tick();
      if (k == DB) isLocked = 1'b0;
      e = expQ.pop_front();
      if (k >= BTN_RISE - 1) begin
        testsRun++;
        if (coreReset !== e.coreReset || resetCause !== e.cause) begin
          testsFailed++;
          $display("[TB] FAIL simultaneous edge %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                   k, coreReset, resetCause, e.coreReset, e.cause);
        end
      end
    end
    extReset = 1'b0;
    repeat (DB + 10) tick();
  endtask

  task automatic test_mid_reset();
    exp_t e;
    isLocked = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      expQ.push_back('{1'b1, C_LOCK});
      tick();
      e = expQ.pop_front();
      testsRun++;
      if (coreReset !== e.coreReset || resetCause !== e.cause) begin
        testsFailed++;
        $display("[TB] FAIL pre_reset edge %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                 k, coreReset, resetCause, e.coreReset, e.cause);
      end
    end
    reset = 1'b1;
    expQ.push_back('{1'b1, C_POR});
    #1;
    e = expQ.pop_front();
    testsRun++;
    if (coreReset !== e.coreReset || resetCause !== e.cause) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
               coreReset, resetCause, e.coreReset, e.cause);
    end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= LOCK_FALL + 1; k++) begin
      expQ.push_back('{(k < LOCK_FALL), C_POR});
      tick();
      e = expQ.pop_front();
      testsRun++;
      if (coreReset !== e.coreReset || resetCause !== e.cause) begin
        testsFailed++;
        $display("[TB] FAIL post_reset edge %0d: got coreReset=%b cause=%0d, want coreReset=%b cause=%0d",
                 k, coreReset, resetCause, e.coreReset, e.cause);
      end
    end
  endtask

`ifdef RESET_SEQ_LOSS_COUNT_EN
  task automatic test_loss_count();
    int model = 0;
    testsRun++;
    if (lossCount !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL loss_count_start: got %0d, want 0", lossCount);
    end
    for (int n = 0; n < 260; n++) begin
      isLocked = 1'b0;
      repeat (3) tick();
      isLocked = 1'b1;
      repeat (LOCK_FALL + 1) tick();
      model = (model == 255) ? 255 : model + 1;
      testsRun++;
      if (lossCount !== 8'(model)) begin
        testsFailed++;
        $display("[TB] FAIL loss_count iter %0d: got %0d, want %0d", n, lossCount, model);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_power_on();
    test_lock_loss();
    test_button_debounce();
    test_stretch_abort();
    test_simultaneous();
    test_mid_reset();
`ifdef RESET_SEQ_LOSS_COUNT_EN
    test_loss_count();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
